// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO with binary pointers one bit wider than the address,
// occupancy count, almost-full/almost-empty flags and a synchronous flush.
module sync_fifo #(
  parameter type         data_type        = logic,
  parameter int unsigned AddrDepth        = 3,
  parameter int unsigned AlmostFullLevel  = 6,
  parameter int unsigned AlmostEmptyLevel = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_i,
  input  data_type           src_data_i,
  input  logic               src_valid_i,
  output logic               src_ready_o,
  output data_type           dst_data_o,
  output logic               dst_valid_o,
  input  logic               dst_ready_i,
  output logic [AddrDepth:0] fill_o,
  output logic               almost_full_o,
  output logic               almost_empty_o
);

  localparam int unsigned PtrW  = AddrDepth + 1;
  localparam int unsigned Depth = 2 ** AddrDepth;

  localparam logic [PtrW-1:0] PtrZero  = {PtrW{1'b0}};
  localparam logic [PtrW-1:0] PtrOne   = {{AddrDepth{1'b0}}, 1'b1};
  localparam logic [PtrW-1:0] FullXor  = {1'b1, {AddrDepth{1'b0}}};
  localparam logic [PtrW-1:0] AfLevel  = PtrW'(AlmostFullLevel);
  localparam logic [PtrW-1:0] AeLevel  = PtrW'(AlmostEmptyLevel);

  data_type          mem_r [Depth];
  logic [PtrW-1:0]   wr_ptr_r;
  logic [PtrW-1:0]   rd_ptr_r;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [PtrW-1:0]   fill_s;

  // Status decode: depends on registered pointers only, never on the handshake inputs.
  always_comb begin
    full_s  = 1'b0;
    empty_s = 1'b0;
    fill_s  = PtrZero;
    if ((wr_ptr_r ^ rd_ptr_r) == FullXor) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (wr_ptr_r == rd_ptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    fill_s = wr_ptr_r - rd_ptr_r;
  end

  assign push_s = src_valid_i & ~full_s;
  assign pop_s  = dst_ready_i & ~empty_s;

  // Pointer registers; flush overrides any handshake in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PtrZero;
      rd_ptr_r <= PtrZero;
    end else if (flush_i) begin
      wr_ptr_r <= PtrZero;
      rd_ptr_r <= PtrZero;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s && !flush_i) begin
      mem_r[wr_ptr_r[AddrDepth-1:0]] <= src_data_i;
    end
  end

  assign src_ready_o    = ~full_s;
  assign dst_valid_o    = ~empty_s;
  assign dst_data_o     = mem_r[rd_ptr_r[AddrDepth-1:0]];
  assign fill_o         = fill_s;
  assign almost_full_o  = (fill_s >= AfLevel);
  assign almost_empty_o = (fill_s <= AeLevel);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (8-bit payload, 8 entries).
module tb_sync_fifo;

  logic       clk;
  logic       reset_n;
  logic       flush_i;
  logic [7:0] src_data_i;
  logic       src_valid_i;
  logic       src_ready_o;
  logic [7:0] dst_data_o;
  logic       dst_valid_o;
  logic       dst_ready_i;
  logic [3:0] fill_o;
  logic       almost_full_o;
  logic       almost_empty_o;

  int tests;
  int failed;

  sync_fifo #(
    .data_type        (logic [7:0]),
    .AddrDepth        (3),
    .AlmostFullLevel  (6),
    .AlmostEmptyLevel (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_i        (flush_i),
    .src_data_i     (src_data_i),
    .src_valid_i    (src_valid_i),
    .src_ready_o    (src_ready_o),
    .dst_data_o     (dst_data_o),
    .dst_valid_o    (dst_valid_o),
    .dst_ready_i    (dst_ready_i),
    .fill_o         (fill_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_fill"},   32'(fill_o), 32'd0);
    chk({tag, "_valid"},  32'(dst_valid_o), 32'd0);
    chk({tag, "_ready"},  32'(src_ready_o), 32'd1);
    chk({tag, "_ae"},     32'(almost_empty_o), 32'd1);
    chk({tag, "_af"},     32'(almost_full_o), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_q [$];
    tests   = 0;
    failed  = 0;
    reset_n = 1'b0;
    flush_i = 1'b0;
    src_data_i  = 8'h00;
    src_valid_i = 1'b1;
    dst_ready_i = 1'b0;

    // 1: reset held with a write request present
    step();
    step();
    chk_idle("reset");
    src_valid_i = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    chk_idle("post_reset");

    // 2: fill with 0x00..0x07, watching flags along the way
    for (int i = 0; i < 8; i++) begin
      src_valid_i = 1'b1;
      src_data_i  = 8'(i);
      chk("fill_ready", 32'(src_ready_o), 32'd1);
      step();
      chk("fill_count", 32'(fill_o), 32'(i + 1));
      chk("fill_af", 32'(almost_full_o), 32'((i + 1) >= 6));
      chk("fill_ae", 32'(almost_empty_o), 32'((i + 1) <= 1));
    end
    chk("full_ready", 32'(src_ready_o), 32'd0);
    chk("full_head", 32'(dst_data_o), 32'h00);
    src_data_i = 8'hFF;
    step();
    chk("full_hold_fill", 32'(fill_o), 32'd8);
    chk("full_hold_ready", 32'(src_ready_o), 32'd0);

    // 4a: full with push+pop -> only the pop happens
    dst_ready_i = 1'b1;
    step();
    chk("full_pp_fill", 32'(fill_o), 32'd7);
    chk("full_pp_ready", 32'(src_ready_o), 32'd1);
    chk("full_pp_head", 32'(dst_data_o), 32'h01);
    // 0xFF now accepted while 0x01 is popped
    step();
    chk("refill_fill", 32'(fill_o), 32'd7);
    src_valid_i = 1'b0;
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF};
    foreach (exp_q[k]) begin
      chk("drain_valid", 32'(dst_valid_o), 32'd1);
      chk("drain_data", 32'(dst_data_o), 32'(exp_q[k]));
      step();
    end
    chk("drain_empty", 32'(dst_valid_o), 32'd0);
    chk("drain_fill", 32'(fill_o), 32'd0);

    // 4b: empty with push+pop -> only the push happens
    src_valid_i = 1'b1;
    src_data_i  = 8'h3C;
    dst_ready_i = 1'b1;
    step();
    chk("empty_pp_fill", 32'(fill_o), 32'd1);
    chk("empty_pp_valid", 32'(dst_valid_o), 32'd1);
    chk("empty_pp_data", 32'(dst_data_o), 32'h3C);

    // 3: streaming for 40 cycles, occupancy pinned at 1
    for (int k = 0; k < 40; k++) begin
      src_data_i = 8'(8'h40 + k);
      chk("stream_valid", 32'(dst_valid_o), 32'd1);
      chk("stream_data", 32'(dst_data_o), (k == 0) ? 32'h3C : 32'(8'h40 + k - 1));
      chk("stream_fill", 32'(fill_o), 32'd1);
      step();
    end
    src_valid_i = 1'b0;
    chk("stream_last", 32'(dst_data_o), 32'h67);
    step();
    chk("stream_drained", 32'(fill_o), 32'd0);

    // 5: flush with a concurrent push and pop
    dst_ready_i = 1'b0;
    src_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_data_i = 8'(8'h10 + i);
      step();
    end
    chk("pre_flush_fill", 32'(fill_o), 32'd5);
    flush_i     = 1'b1;
    src_data_i  = 8'h77;
    dst_ready_i = 1'b1;
    chk("flush_cycle_ready", 32'(src_ready_o), 32'd1);
    step();
    flush_i     = 1'b0;
    src_valid_i = 1'b0;
    dst_ready_i = 1'b0;
    chk_idle("flush");
    src_valid_i = 1'b1;
    src_data_i  = 8'hA5;
    step();
    src_valid_i = 1'b0;
    chk("post_flush_valid", 32'(dst_valid_o), 32'd1);
    chk("post_flush_data", 32'(dst_data_o), 32'hA5);
    dst_ready_i = 1'b1;
    step();
    dst_ready_i = 1'b0;
    chk("post_flush_fill", 32'(fill_o), 32'd0);

    // 6: asynchronous reset between clock edges at fill 4
    src_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data_i = 8'(8'h20 + i);
      step();
    end
    src_valid_i = 1'b0;
    chk("pre_areset_fill", 32'(fill_o), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("areset");
    #1;
    reset_n = 1'b1;
    step();
    chk_idle("after_areset");
    src_valid_i = 1'b1;
    src_data_i  = 8'h5A;
    step();
    src_valid_i = 1'b0;
    chk("after_areset_data", 32'(dst_data_o), 32'h5A);
    chk("after_areset_fill", 32'(fill_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
